// File: rtl/uart_wbm_pkg.sv
// Shared definitions for the UART Wishbone initiator: slave register map,
// status bit positions and the polling FSM state encoding.
package uart_wbm_pkg;

  localparam logic ADR_DATA = 1'b0;
  localparam logic ADR_CSR  = 1'b1;

  localparam int ST_TXRDY = 7;
  localparam int ST_RXRDY = 3;
  localparam int ST_BRK   = 2;
  localparam int ST_PERR  = 1;
  localparam int ST_OVF   = 0;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    POLL   = 3'd1,
    DECIDE = 3'd2,
    RD_RBR = 3'd3,
    WR_THR = 3'd4,
    GAP    = 3'd5
  } state_t;

  function automatic logic is_bus_state(input state_t s);
    return (s == INIT) || (s == POLL) || (s == RD_RBR) || (s == WR_THR);
  endfunction

endpackage

// File: rtl/uart_wbm_bridge_xfer.sv
// Single-transfer Wishbone engine: launches one cycle on i_start, ends it on
// ack (done) or after ACK_TMO clocks without ack (tmo).
module wbm_xfer #(
  parameter int ACK_TMO = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_we,
  input  logic       i_adr,
  input  logic [7:0] i_wdat,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tmo,
  output logic [7:0] o_rdat,
  output logic       o_cyc,
  output logic       o_stb,
  output logic       o_we,
  output logic       o_adr,
  output logic [7:0] o_dat,
  input  logic [7:0] i_dat,
  input  logic       i_ack
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

  logic       r_cyc;
  logic       r_we;
  logic       r_adr;
  logic [7:0] r_dat;
  logic [7:0] r_cnt;
  logic       w_ack;
  logic       w_tmo;

  assign w_ack = r_cyc & i_ack;
  assign w_tmo = r_cyc & ~i_ack & (r_cnt == TMO_LAST);

  // Address, direction and write data are latched at launch and held until the cycle ends.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_adr <= 1'b0;
      r_dat <= 8'h00;
      r_cnt <= 8'h00;
    end else if (!r_cyc) begin
      if (i_start) begin
        r_cyc <= 1'b1;
        r_we  <= i_we;
        r_adr <= i_adr;
        r_dat <= i_wdat;
        r_cnt <= 8'h00;
      end
    end else if (w_ack || w_tmo) begin
      r_cyc <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 8'h01;
    end
  end

  assign o_busy = r_cyc;
  assign o_done = w_ack;
  assign o_tmo  = w_tmo;
  assign o_rdat = i_dat;
  assign o_cyc  = r_cyc;
  assign o_stb  = r_cyc;
  assign o_we   = r_we;
  assign o_adr  = r_adr;
  assign o_dat  = r_dat;

endmodule

// File: rtl/uart_wbm_bridge.sv
// Wishbone initiator for the 8251-style UART slave: polls CSR, moves bytes
// between the slave and single-entry tx/rx valid/ready buffers.
module uart_wbm_bridge
  import uart_wbm_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int ACK_TMO  = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic       wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  input  logic       wb_ack_i,
  input  logic [7:0] tx_dat_i,
  input  logic       tx_vld_i,
  output logic       tx_rdy_o,
  output logic [7:0] rx_dat_o,
  output logic [2:0] rx_err_o,
  output logic       rx_vld_o,
  input  logic       rx_rdy_i,
  output logic       tmo_o
);

  localparam int GAP_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_st_tx;
  logic             r_st_rx;
  logic [2:0]       r_st_err;
  logic             r_fair;
  logic             r_tmo;
  logic [GAP_W-1:0] r_gap;
  logic             r_tx_full;
  logic [7:0]       r_tx_dat;
  logic             r_rx_full;
  logic [7:0]       r_rx_dat;
  logic [2:0]       r_rx_err;

  logic       w_start;
  logic       w_we;
  logic       w_adr;
  logic [7:0] w_wdat;
  logic       w_busy;
  logic       w_done;
  logic       w_tmo;
  logic [7:0] w_rdat;
  logic       w_tx_load;
  logic       w_wr_ok;
  logic       w_rd_ok;

  wbm_xfer #(.ACK_TMO(ACK_TMO)) u_xfer (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_i),
    .i_start (w_start),
    .i_we    (w_we),
    .i_adr   (w_adr),
    .i_wdat  (w_wdat),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_tmo   (w_tmo),
    .o_rdat  (w_rdat),
    .o_cyc   (wb_cyc_o),
    .o_stb   (wb_stb_o),
    .o_we    (wb_we_o),
    .o_adr   (wb_adr_o),
    .o_dat   (wb_dat_o),
    .i_dat   (wb_dat_i),
    .i_ack   (wb_ack_i)
  );

  assign tx_rdy_o  = ~r_tx_full & (r_state != INIT);
  assign w_tx_load = tx_vld_i & tx_rdy_o;

  // rx wins unless the previous pick was a read and a tx byte is waiting.
  assign w_wr_ok = r_st_tx & r_tx_full;
  assign w_rd_ok = r_st_rx & ~r_rx_full & ~(r_fair & w_wr_ok);

  always_comb begin
    w_next  = r_state;
    w_start = is_bus_state(r_state) & ~w_busy;
    w_we    = 1'b0;
    w_adr   = ADR_CSR;
    w_wdat  = 8'h00;
    case (r_state)
      INIT: begin
        w_we = 1'b1;
        if (w_done || w_tmo) w_next = GAP;
      end
      POLL: begin
        if (w_done)     w_next = DECIDE;
        else if (w_tmo) w_next = GAP;
      end
      DECIDE: begin
        if (w_rd_ok)      w_next = RD_RBR;
        else if (w_wr_ok) w_next = WR_THR;
        else              w_next = GAP;
      end
      RD_RBR: begin
        w_adr = ADR_DATA;
        if (w_done)     w_next = POLL;
        else if (w_tmo) w_next = GAP;
      end
      WR_THR: begin
        w_we   = 1'b1;
        w_adr  = ADR_DATA;
        w_wdat = r_tx_dat;
        if (w_done)     w_next = POLL;
        else if (w_tmo) w_next = GAP;
      end
      GAP: begin
        if (w_tx_load || (r_gap == GAP_LAST)) w_next = POLL;
      end
      default: w_next = INIT;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state  <= INIT;
      r_st_tx  <= 1'b0;
      r_st_rx  <= 1'b0;
      r_st_err <= 3'b000;
      r_fair   <= 1'b0;
      r_tmo    <= 1'b0;
      r_gap    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == POLL) && w_done) begin
        r_st_tx  <= w_rdat[ST_TXRDY];
        r_st_rx  <= w_rdat[ST_RXRDY];
        r_st_err <= {w_rdat[ST_BRK], w_rdat[ST_PERR], w_rdat[ST_OVF]};
      end
      if ((r_state == RD_RBR) && w_done) r_fair <= 1'b1;
      else if ((r_state == WR_THR) && w_done) r_fair <= 1'b0;
      if (w_tmo) r_tmo <= 1'b1;
      r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
    end
  end

  // A timed-out THR write leaves the byte in place so it is retried.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_tx_full <= 1'b0;
      r_tx_dat  <= 8'h00;
    end else if (w_tx_load) begin
      r_tx_full <= 1'b1;
      r_tx_dat  <= tx_dat_i;
    end else if ((r_state == WR_THR) && w_done) begin
      r_tx_full <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_rx_full <= 1'b0;
      r_rx_dat  <= 8'h00;
      r_rx_err  <= 3'b000;
    end else if ((r_state == RD_RBR) && w_done) begin
      r_rx_full <= 1'b1;
      r_rx_dat  <= w_rdat;
      r_rx_err  <= r_st_err;
    end else if (r_rx_full && rx_rdy_i) begin
      r_rx_full <= 1'b0;
    end
  end

  assign rx_vld_o = r_rx_full;
  assign rx_dat_o = r_rx_dat;
  assign rx_err_o = r_rx_err;
  assign tmo_o    = r_tmo;

endmodule

// File: tb/tb_uart_wbm_bridge.sv
// Scoreboard bench for uart_wbm_bridge against a simple registered-ack UART
// slave model; bus and rx monitors pop expectations queued by the stimulus.
module tb_uart_wbm_bridge;

  localparam int POLL_GAP = 4;
  localparam int ACK_TMO  = 8;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic       wb_ack_i = 1'b0;
  logic [7:0] tx_dat_i;
  logic       tx_vld_i;
  logic       tx_rdy_o;
  logic [7:0] rx_dat_o;
  logic [2:0] rx_err_o;
  logic       rx_vld_o;
  logic       rx_rdy_i;
  logic       tmo_o;

  logic [7:0] csr_val;
  logic [7:0] rbr_val;
  logic       noack;

  typedef struct packed { logic we; logic adr; logic [7:0] dat; } bus_t;
  typedef struct packed { logic [7:0] dat; logic [2:0] err; } rx_t;
  bus_t bus_q[$];
  rx_t  rx_q[$];

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  uart_wbm_bridge #(.POLL_GAP(POLL_GAP), .ACK_TMO(ACK_TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_ack_i (wb_ack_i),
    .tx_dat_i (tx_dat_i),
    .tx_vld_i (tx_vld_i),
    .tx_rdy_o (tx_rdy_o),
    .rx_dat_o (rx_dat_o),
    .rx_err_o (rx_err_o),
    .rx_vld_o (rx_vld_o),
    .rx_rdy_i (rx_rdy_i),
    .tmo_o    (tmo_o)
  );

  // Slave: one-clock registered ack pulse per strobe.
  always @(posedge clk) wb_ack_i <= wb_cyc_o & wb_stb_o & ~wb_ack_i & ~noack;
  assign wb_dat_i = wb_adr_o ? csr_val : rbr_val;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout/unexpected required expected event", nm);
  endtask

  // Bus monitor: every completed transfer except CSR polls is scoreboarded.
  always @(negedge clk) begin
    if (wb_rst_i && wb_cyc_o && wb_stb_o && wb_ack_i && !(!wb_we_o && wb_adr_o)) begin
      if (bus_q.size() == 0) begin
        fail("bus_unexpected_xfer");
      end else begin
        bus_t e;
        e = bus_q.pop_front();
        chk("bus_we", wb_we_o, e.we);
        chk("bus_adr", wb_adr_o, e.adr);
        if (e.we) chk("bus_wdat", wb_dat_o, e.dat);
      end
    end
  end

  always @(negedge clk) begin
    if (wb_rst_i && rx_vld_o && rx_rdy_i) begin
      if (rx_q.size() == 0) begin
        fail("rx_unexpected_byte");
      end else begin
        rx_t r;
        r = rx_q.pop_front();
        chk("rx_dat", rx_dat_o, r.dat);
        chk("rx_err", rx_err_o, r.err);
      end
    end
  end

  task automatic wait_cyc(input logic v, input string nm);
    int n = 0;
    while (wb_cyc_o !== v && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (wb_cyc_o !== v) fail(nm);
  endtask

  task automatic wait_bus_empty(input string nm);
    int n = 0;
    while (bus_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus_q.size(), 0);
  endtask

  task automatic wait_rx_empty(input string nm);
    int n = 0;
    while (rx_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, rx_q.size(), 0);
  endtask

  task automatic send_tx(input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    while (!tx_rdy_o && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tx_rdy_o) begin
      fail("tx_rdy_never_high");
    end else begin
      tx_dat_i = b;
      tx_vld_i = 1'b1;
      @(posedge clk); #1;
      tx_vld_i = 1'b0;
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!wb_cyc_o && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (wb_cyc_o && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit required completion");
    $fatal(1);
  end

  initial begin
    int n;
    int nw;
    wb_rst_i = 1'b0;
    tx_dat_i = 8'h00;
    tx_vld_i = 1'b0;
    rx_rdy_i = 1'b0;
    csr_val  = 8'h00;
    rbr_val  = 8'h00;
    noack    = 1'b0;

    // Reset state and the INIT CSR write.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_tx_rdy", tx_rdy_o, 1'b0);
    chk("rst_rx_vld", rx_vld_o, 1'b0);
    chk("rst_tmo", tmo_o, 1'b0);
    bus_q.push_back('{we: 1'b1, adr: 1'b1, dat: 8'h00});
    @(posedge clk); #1;
    wb_rst_i = 1'b1;
    wait_bus_empty("init_write_seen");
    @(negedge clk);
    chk("tx_rdy_after_init", tx_rdy_o, 1'b1);

    // Idle poll spacing: cyc stays low POLL_GAP+2 clocks between polls.
    wait_cyc(1'b0, "init_end");
    wait_cyc(1'b1, "poll1_start");
    wait_cyc(1'b0, "poll1_end");
    count_low(n);
    chk("poll_spacing_a", n, POLL_GAP + 2);
    wait_cyc(1'b0, "poll2_end");
    count_low(n);
    chk("poll_spacing_b", n, POLL_GAP + 2);

    // Rx with client stalled: exactly one RBR read.
    rbr_val = 8'h5A;
    bus_q.push_back('{we: 1'b0, adr: 1'b0, dat: 8'h5A});
    rx_q.push_back('{dat: 8'h5A, err: 3'b000});
    @(negedge clk);
    csr_val = 8'h88;
    repeat (80) @(negedge clk);
    chk("rx_stall_vld", rx_vld_o, 1'b1);
    chk("rx_stall_dat", rx_dat_o, 8'h5A);
    chk("rx_stall_err", rx_err_o, 3'b000);
    chk("rx_stall_one_read", bus_q.size(), 0);
    csr_val = 8'h00;
    repeat (20) @(negedge clk);
    rx_rdy_i = 1'b1;
    wait_rx_empty("rx_stall_accepted");

    // Single tx byte with tx_ready only.
    csr_val = 8'h80;
    bus_q.push_back('{we: 1'b1, adr: 1'b0, dat: 8'hA5});
    send_tx(8'hA5);
    @(negedge clk);
    n = 0;
    while (!(wb_cyc_o && wb_we_o && !wb_adr_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tx_rdy_during_write", tx_rdy_o, 1'b0);
    n = 0;
    while (!wb_ack_i && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tx_rdy_at_ack", tx_rdy_o, 1'b0);
    @(negedge clk);
    chk("tx_rdy_after_ack", tx_rdy_o, 1'b1);
    repeat (40) @(negedge clk);
    chk("tx_single_write", bus_q.size(), 0);
    csr_val = 8'h00;

    // Fairness: rx and tx both pending, reads and writes alternate.
    rbr_val = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      bus_q.push_back('{we: 1'b0, adr: 1'b0, dat: 8'h3C});
      bus_q.push_back('{we: 1'b1, adr: 1'b0, dat: 8'(8'h11 * (i + 1))});
      rx_q.push_back('{dat: 8'h3C, err: 3'b111});
    end
    send_tx(8'h11);
    @(negedge clk);
    csr_val = 8'h8F;
    fork
      begin
        send_tx(8'h22);
        send_tx(8'h33);
      end
      begin
        nw = 0;
        n  = 0;
        while (nw < 3 && n < 2000) begin
          @(negedge clk);
          n++;
          if (wb_cyc_o && wb_ack_i && wb_we_o && !wb_adr_o) nw++;
        end
        csr_val = 8'h00;
        chk("fair_write_count", nw, 3);
      end
    join
    wait_bus_empty("fair_bus_done");
    wait_rx_empty("fair_rx_done");

    // Ack timeout: cycle aborted after ACK_TMO clocks, sticky flag, polling resumes.
    @(negedge clk);
    wait_cyc(1'b0, "tmo_idle");
    noack = 1'b1;
    wait_cyc(1'b1, "tmo_cycle_start");
    count_high(n);
    chk("tmo_cyc_len", n, ACK_TMO);
    chk("tmo_flag_set", tmo_o, 1'b1);
    noack = 1'b0;
    n = 0;
    while (!(wb_cyc_o && wb_ack_i) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_resume_poll", wb_cyc_o && wb_ack_i, 1'b1);
    @(negedge clk);
    chk("tmo_sticky", tmo_o, 1'b1);

    // Reset while a cycle is in flight.
    wait_cyc(1'b0, "rst_mid_idle");
    wait_cyc(1'b1, "rst_mid_start");
    chk("rst_mid_stb_before", wb_stb_o, 1'b1);
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_stb", wb_stb_o, 1'b0);
    chk("rst_mid_cyc", wb_cyc_o, 1'b0);
    chk("rst_mid_we", wb_we_o, 1'b0);
    chk("rst_mid_adr", wb_adr_o, 1'b0);
    chk("rst_mid_dat", wb_dat_o, 8'h00);
    chk("rst_mid_tx_rdy", tx_rdy_o, 1'b0);
    chk("rst_mid_rx_vld", rx_vld_o, 1'b0);
    chk("rst_mid_rx_dat", rx_dat_o, 8'h00);
    chk("rst_mid_rx_err", rx_err_o, 3'b000);
    chk("rst_mid_tmo", tmo_o, 1'b0);
    bus_q.push_back('{we: 1'b1, adr: 1'b1, dat: 8'h00});
    @(posedge clk); #1;
    wb_rst_i = 1'b1;
    wait_bus_empty("rst_mid_init_repeat");
    @(negedge clk);
    chk("rst_mid_tx_rdy_after", tx_rdy_o, 1'b1);

    repeat (20) @(negedge clk);
    chk("final_bus_q_empty", bus_q.size(), 0);
    chk("final_rx_q_empty", rx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_wbm_bridge.md
Name: uart_wbm_bridge

Overview:
- Wishbone initiator that drives the team's 8251-style Wishbone UART slave. It polls the status register, pulls received bytes and pushes transmit bytes.
- Presents plain valid/ready byte streams (TX in, RX out) to a local client, e.g. a console or debug monitor, so the client never performs bus cycles.
- Sits between that client and the UART slave on a private point-to-point Wishbone link.

Parameters:
- POLL_GAP, 16: idle clocks between status polls when nothing moved; 0 means back-to-back polling.
- ACK_TMO, 255: clocks to wait for ack before a cycle is aborted; 8-bit counter.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, synchronous, active-low
- wb_adr_o  out  1  register select: 0 = data (RBR/THR), 1 = CSR
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_ack_i  in  1  slave acknowledge
- tx_dat_i  in  8  byte to transmit
- tx_vld_i  in  1  tx byte valid
- tx_rdy_o  out  1  bridge can accept a tx byte
- rx_dat_o  out  8  received byte
- rx_err_o  out  3  {break, parity error, overrun} captured with the byte
- rx_vld_o  out  1  rx byte valid
- rx_rdy_i  in  1  client accepts rx byte
- tmo_o  out  1  sticky ack-timeout flag

Behaviour:
- Reset (wb_rst_i=0 at a clock edge):
  - FSM to INIT; cyc/stb/we/adr/wb_dat_o = 0.
  - tx_rdy_o=0, rx_vld_o=0, rx_dat_o=0, rx_err_o=0, tmo_o=0.
  - Tx and rx holding buffers are emptied.
  - Reset mid-cycle drops cyc/stb on the next edge and performs no capture.
- Bus cycle: cyc_o and stb_o assert together and stay high until ack_i is sampled high. On that ack edge both are deasserted.
  - Each transfer is therefore exactly one ack pulse; the slave's ack self-clears.
  - Read data is captured on the ack edge.
  - Minimum transfer is 2 clocks; adr/we/dat are held stable for the whole cycle.
- Timeout: an 8-bit counter starts at cycle start. At ACK_TMO clocks without ack:
  - cyc/stb drop and tmo_o sets; it is sticky until reset.
  - FSM goes to GAP; data from the aborted read is discarded.
  - An aborted THR write keeps its tx byte for retry.
- FSM states and transitions:
  - INIT: write CSR=0x00 (clears tx break) -> GAP.
  - POLL: read CSR -> DECIDE.
  - DECIDE uses the captured status: s[7]=tx_ready, s[3]=rx_ready, s[2:0]={break,perr,ovf}.
    - If s[3] and the rx buffer is empty -> RD_RBR.
    - Else if s[7] and the tx buffer is full -> WR_THR.
    - Else -> GAP.
  - RD_RBR: read adr 0; load rx buffer with the data and status s[2:0] -> POLL (immediate re-poll).
  - WR_THR: write adr 0 with the tx buffer; empty the tx buffer on ack -> POLL.
  - GAP: count POLL_GAP clocks -> POLL. GAP exits early when the tx buffer becomes full.
- Priority: rx beats tx, to avoid UART overrun.
  - Starvation bound for tx: after one RD_RBR, the next DECIDE that has s[7] set and the tx buffer full takes WR_THR even if s[3] is set.
  - Implemented as a 1-bit fairness toggle.
- Tx buffer, 1 entry:
  - tx_rdy_o = buffer empty and FSM not in INIT.
  - tx_vld_i & tx_rdy_o loads it.
  - It is emptied on the WR_THR ack edge. tx_rdy_o rises on the following clock; no same-cycle refill.
- Rx buffer, 1 entry:
  - rx_vld_o high while full; cleared by rx_vld_o & rx_rdy_i.
  - A simultaneous clear and load cannot occur, because RD_RBR is only entered when the buffer is empty.
  - rx_dat_o and rx_err_o are stable while rx_vld_o is high.
- Widths: POLL_GAP counter is $clog2(POLL_GAP+1) bits, with a minimum of 1. POLL_GAP=0 makes GAP last one clock.

Decomposition:
- Package uart_wbm_pkg holds:
  - register addresses ADR_DATA=0, ADR_CSR=1;
  - status bit indices ST_TXRDY=7, ST_RXRDY=3, ST_BRK=2, ST_PERR=1, ST_OVF=0;
  - FSM state enum (INIT, POLL, DECIDE, RD_RBR, WR_THR, GAP).
- Sub-module wbm_xfer: single-transfer Wishbone engine (start, we, adr, wdat -> done, rdat, tmo), holding the ack and timeout logic. The FSM plus buffers stay in the top level.

Test Plan:
- Reset, then idle slave: first cycle is a write adr=1 dat=0x00; tx_rdy_o=1 afterwards. CSR polls are then spaced POLL_GAP+2 clocks apart.
- Status 0x88, RBR=0x5A: bridge reads adr 0 -> rx_vld_o=1, rx_dat_o=0x5A, rx_err_o=0. With rx_rdy_i held 0, no further RBR read occurs despite rx_ready.
- tx_vld_i with 0xA5 and status 0x80: exactly one write adr=0 dat=0xA5. tx_rdy_o is low during the write and high one clock after its ack.
- Status 0x8F continuously with a tx byte pending: reads and writes alternate (fairness); rx_err_o=3'b111 on the captured byte.
- Slave never acks, ACK_TMO=8: cyc_o drops after 8 clocks, tmo_o=1 and stays set; the bridge resumes polling.
- Assert wb_rst_i=0 while stb_o is high: stb_o=0 next clock, all outputs at reset values, and the INIT write repeats after release.
